// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter: rotating-priority search, registered one-hot grant held until the owner releases.
// Define RR_ARB_TIMEOUT_EN to add hold-timeout preemption after MAX_HOLD cycles.
module rr_arbiter_ctrl #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 grant_valid,
    output logic                 preempt
);

    localparam int              PW      = $clog2(N);
    localparam logic [PW-1:0]   LAST_ID = PW'(N - 1);
    localparam logic [PW:0]     N_EXT   = (PW + 1)'(N);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [N-1:0]   grant_n;
    logic [PW-1:0]  grant_id_n;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  ptr_n;
    logic [PW-1:0]  next_ptr;
    logic [PW-1:0]  winner;
    logic [PW-1:0]  cand;
    logic [PW:0]    sum;
    logic           found;
    logic           owner_req;
    logic           release_now;

    if (N < 2 || MAX_HOLD < 2) begin : g_bad_params
        $error("rr_arbiter_ctrl: requires N >= 2 and MAX_HOLD >= 2");
    end

    assign owner_req   = req[grant_id];
    assign next_ptr    = (grant_id == LAST_ID) ? '0 : grant_id + PW'(1);
    assign grant_valid = |grant;

    // Walk ptr, ptr+1, ... modulo N; the first requester seen wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW + 1)'(k);
            if (sum >= N_EXT) begin
                sum = sum - N_EXT;
            end
            cand = sum[PW-1:0];
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int            HW         = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_cnt_n;
    logic          preempt_q;
    logic          preempt_n;
    logic          others;

    assign others  = |(req & ~grant);
    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        grant_n     = grant;
        grant_id_n  = grant_id;
        ptr_n       = ptr;
        release_now = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        hold_cnt_n  = hold_cnt;
        preempt_n   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (en && found) begin
                    state_n            = GRANT;
                    grant_n            = '0;
                    grant_n[winner]    = 1'b1;
                    grant_id_n         = winner;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_cnt_n         = '0;
`endif
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    release_now = 1'b1;
                end
`ifdef RR_ARB_TIMEOUT_EN
                // Only preempt when someone else is waiting; a lone owner keeps the grant.
                else if (hold_cnt >= HOLD_LAST && others) begin
                    release_now = 1'b1;
                    preempt_n   = 1'b1;
                end else if (hold_cnt != HOLD_LIMIT) begin
                    hold_cnt_n  = hold_cnt + HW'(1);
                end
`endif
            end
            default: state_n = IDLE;
        endcase

        if (release_now) begin
            state_n    = IDLE;
            grant_n    = '0;
            grant_id_n = '0;
            ptr_n      = next_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            grant_id <= grant_id_n;
            ptr      <= ptr_n;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= '0;
            preempt_q <= 1'b0;
        end else begin
            hold_cnt  <= hold_cnt_n;
            preempt_q <= preempt_n;
        end
    end
`endif

endmodule

// File: doc/rr_arbiter_ctrl.md
# rr_arbiter_ctrl

Round-robin arbiter that shares one downstream resource among N requesters. A rotating-priority search picks the winner, and the grant is held until the owner drops its request. It sits between requester ports and the shared datapath. It provides a registered one-hot grant plus an encoded owner index, which can drive a mux select directly. An optional hold timeout forces preemption of owners that keep the grant too long.

## Interface
- `N`, 4, number of requesters; legal range N ≥ 2.
- `MAX_HOLD`, 16, maximum grant duration in cycles before preemption. Used only with the timeout feature; legal range MAX_HOLD ≥ 2.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `en`  input  1  enables new grants; does not revoke a grant already held.
- `req`  input  N  request vector; bit i = requester i.
- `grant`  output  N  registered one-hot grant; all-zero when idle.
- `grant_id`  output  $clog2(N)  index of the owner; 0 when `grant_valid`=0.
- `grant_valid`  output  1  high while any grant is held (equals |grant).
- `preempt`  output  1  one-cycle pulse on a timeout-forced release.

## Operation
- State `ptr` ($clog2(N) bits) holds the highest-priority index for the next search.
- Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1, all mod N. The first set `req` bit in that order wins.
- FSM has two states, IDLE and GRANT.
- IDLE, if `en`=1 and |req=1: register the winner into `grant`/`grant_id`, set `grant_valid`=1, clear `hold_cnt`, go to GRANT. Otherwise stay in IDLE with outputs at 0.
- GRANT, if `req[grant_id]`=0 (release):
  - clear `grant`, `grant_id`, `grant_valid`;
  - ptr ← (grant_id+1) mod N;
  - go to IDLE.
- GRANT, if `req[grant_id]`=1: hold the grant and increment `hold_cnt`.
- `en` falling while in GRANT has no effect on the current owner. After release, the FSM stays in IDLE until `en`=1.
- Requests from non-owners while in GRANT are ignored, not queued. The requester must keep `req` high to be considered.
- Wrap-around: when grant_id=N-1 is released, ptr becomes 0.
- Releasing one cycle after the grant is legal: a single-cycle grant.

## Timing
- Reset values: grant=0, grant_id=0, grant_valid=0, preempt=0, ptr=0, hold_cnt=0, FSM=IDLE.
- Reset during GRANT drops the grant at that edge with no preempt pulse.
- Grant latency: `req` sampled high at edge k (IDLE, en=1) → `grant` visible after edge k.
- Release latency: owner `req` low at edge k → `grant`=0 after edge k.
- Exactly one IDLE cycle separates consecutive grants, so handover is always grant → 0 → next grant. Back-to-back grants without that gap are not allowed.
- Release and a new request arriving at the same edge: the release wins. The new request is evaluated in the following IDLE cycle with the updated ptr.
- `hold_cnt` is $clog2(MAX_HOLD+1) bits wide and saturates at MAX_HOLD.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined, forced release: triggered when the owner has held the grant for MAX_HOLD cycles (hold_cnt = MAX_HOLD-1 while `req[grant_id]` is still 1) and at least one other `req` bit is set. At that edge:
  - grant is released;
  - ptr ← (grant_id+1) mod N;
  - `preempt` pulses high for one cycle, coincident with the first IDLE cycle;
  - FSM goes to IDLE.
- `RR_ARB_TIMEOUT_EN` defined, owner is the only requester: no preemption; hold_cnt saturates and the grant is kept.
- `RR_ARB_TIMEOUT_EN` not defined: hold counter logic is omitted, `preempt` is tied to 0, and grants are held until voluntary release.

## Test plan
- Reset: drive rst=1 for 2 cycles with req=4'b1111, en=1. Then grant=0, grant_id=0, grant_valid=0, preempt=0. The first grant after rst deasserts is 4'b0001.
- Basic grant and handover: from reset, set req=4'b0110. Expect grant=0010 and grant_id=1 one cycle later. Drop req[1] → grant=0 for one cycle, then grant=0100, grant_id=2.
- Rotation and wrap: hold req=4'b1111. Each owner drops its bit for 1 cycle after 2 cycles of grant, then re-raises it. Grant sequence must be id 0,1,2,3,0, with one idle cycle between each grant.
- Enable gating: en=0 with req=4'b1000 → no grant for 10 cycles. Set en=1 → grant=1000. Then set en=0 → grant retained until req[3] drops, then IDLE persists.
- Timeout, with macro and MAX_HOLD=4: req=4'b0011 held forever. Expect grant=0001 for 4 cycles, then grant=0 with preempt=1, then grant=0010. With req=4'b0001 only, the grant is held indefinitely and preempt stays 0. Without the macro, req=0011 holds grant=0001 indefinitely.
- Reset mid-grant: owner id 2 holding, assert rst → all outputs 0 at that edge, ptr=0. After release of rst with req=4'b0101, grant=0001.
